// File: rtl/mux4_rr_arbiter.sv
// rtl/mux4_rr_arbiter.sv - round-robin 4:1 arbiter/mux with one-entry valid/ready output register (optional ARB_GRANT_CNT_EN)
module mux4_rr_arbiter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       req,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic [WIDTH-1:0] in3,
    input  logic [WIDTH-1:0] in4,
    output logic [3:0]       gnt,
    output logic [1:0]       sel,
    output logic [WIDTH-1:0] out,
    output logic [1:0]       out_src,
    output logic             out_valid,
    input  logic             out_ready
`ifdef ARB_GRANT_CNT_EN
    ,
    output logic [63:0]      grant_cnt
`endif
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [1:0]       ptr;
    logic [1:0]       sel_q;
    logic [1:0]       start;
    logic [7:0]       req_dbl;
    logic [3:0]       req_rot;
    logic [1:0]       rot_idx;
    logic [1:0]       winner;
    logic             capture_ok;
    logic             grant_en;
    logic [WIDTH-1:0] mux_data;

    // Rotate the request vector so the requester after the last winner sits in bit 0
    always_comb begin
        start   = ptr + 2'd1;
        req_dbl = {req, req};
        req_rot = req_dbl[start +: 4];
        rot_idx = 2'd0;
        if (req_rot[0])      rot_idx = 2'd0;
        else if (req_rot[1]) rot_idx = 2'd1;
        else if (req_rot[2]) rot_idx = 2'd2;
        else                 rot_idx = 2'd3;
        winner = start + rot_idx;
    end

    // Grant only when the output slot is free or being drained this cycle; never during reset
    always_comb begin
        capture_ok = (state == EMPTY) || out_ready;
        grant_en   = !rst && capture_ok && (req != 4'd0);
        gnt        = grant_en ? (4'b0001 << winner) : 4'b0000;
        sel        = grant_en ? winner : sel_q;
    end

    // Shared 4:1 datapath mux driven by the select
    always_comb begin
        mux_data = in1;
        case (sel)
            2'd0:    mux_data = in1;
            2'd1:    mux_data = in2;
            2'd2:    mux_data = in3;
            default: mux_data = in4;
        endcase
    end

    // Output-slot state register
    always_ff @(posedge clk) begin
        if (rst) state <= EMPTY;
        else     state <= state_next;
    end

    // Output-slot next state: capture fills, an unrefilled drain empties
    always_comb begin
        state_next = state;
        case (state)
            EMPTY: begin
                if (grant_en) state_next = FULL;
            end
            FULL: begin
                if (grant_en)       state_next = FULL;
                else if (out_ready) state_next = EMPTY;
            end
            default: state_next = EMPTY;
        endcase
    end

    assign out_valid = (state == FULL);

    // Capture the winning word; pointer and select copy follow the winner
    always_ff @(posedge clk) begin
        if (rst) begin
            out     <= '0;
            out_src <= 2'd0;
            ptr     <= 2'd3;
            sel_q   <= 2'd0;
        end else if (grant_en) begin
            out     <= mux_data;
            out_src <= winner;
            ptr     <= winner;
            sel_q   <= winner;
        end
    end

`ifdef ARB_GRANT_CNT_EN
    logic [15:0] cnt [4];

    // Per-requester saturating grant counters
    always_ff @(posedge clk) begin
        for (int n = 0; n < 4; n++) begin
            if (rst)                             cnt[n] <= 16'd0;
            else if (gnt[n] && cnt[n] != 16'hFFFF) cnt[n] <= cnt[n] + 16'd1;
        end
    end

    assign grant_cnt = {cnt[3], cnt[2], cnt[1], cnt[0]};
`endif

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// tb/tb_mux4_rr_arbiter.sv - self-checking bench for mux4_rr_arbiter with reference model
module tb_mux4_rr_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [31:0] din [4];
    logic [3:0]  gnt;
    logic [1:0]  sel;
    logic [31:0] out;
    logic [1:0]  out_src;
    logic        out_valid;
    logic        out_ready;
`ifdef ARB_GRANT_CNT_EN
    logic [63:0] grant_cnt;
`endif

    mux4_rr_arbiter #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .in1       (din[0]),
        .in2       (din[1]),
        .in3       (din[2]),
        .in4       (din[3]),
        .gnt       (gnt),
        .sel       (sel),
        .out       (out),
        .out_src   (out_src),
        .out_valid (out_valid),
        .out_ready (out_ready)
`ifdef ARB_GRANT_CNT_EN
        ,
        .grant_cnt (grant_cnt)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // reference model state
    int          m_ptr;
    logic [31:0] m_out;
    int          m_src;
    bit          m_valid;
    int          m_sel;
    int          m_cnt [4];

    // values seen at the last sampling point
    logic [3:0]  s_gnt;
    logic [1:0]  s_sel;
    logic [31:0] s_out;
    logic [1:0]  s_src;
    logic        s_valid;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int pick_winner(input logic [3:0] r, input int p);
        for (int k = 1; k <= 4; k++) begin
            if (r[(p + k) % 4]) return (p + k) % 4;
        end
        return -1;
    endfunction

    // one clock cycle: compare at negedge against the model, advance the model at posedge
    task automatic cycle();
        int w;
        logic [3:0] e_gnt;
        @(negedge clk);
        w = -1;
        if (!rst && (!m_valid || out_ready)) w = pick_winner(req, m_ptr);
        e_gnt = (w >= 0) ? 4'(1 << w) : 4'd0;
        s_gnt = gnt; s_sel = sel; s_out = out; s_src = out_src; s_valid = out_valid;
        check("gnt", {60'd0, gnt}, {60'd0, e_gnt});
        check("sel", {62'd0, sel}, 64'((w >= 0) ? w : m_sel));
        check("out_valid", {63'd0, out_valid}, {63'd0, m_valid});
        if (m_valid) begin
            check("out", {32'd0, out}, {32'd0, m_out});
            check("out_src", {62'd0, out_src}, 64'(m_src));
        end
`ifdef ARB_GRANT_CNT_EN
        for (int n = 0; n < 4; n++)
            check("grant_cnt", {48'd0, grant_cnt[16*n +: 16]}, 64'(m_cnt[n]));
`endif
        @(posedge clk);
        if (rst) begin
            m_ptr = 3; m_out = 0; m_src = 0; m_valid = 0; m_sel = 0;
            for (int n = 0; n < 4; n++) m_cnt[n] = 0;
        end else if (w >= 0) begin
            m_out = din[w]; m_src = w; m_ptr = w; m_valid = 1; m_sel = w;
            if (m_cnt[w] < 65535) m_cnt[w]++;
        end else if (m_valid && out_ready) begin
            m_valid = 0;
        end
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
    endtask

    logic [3:0] pend;
    logic [3:0] pat_gnt [5];
    logic [31:0] pat_out [4];

    initial begin
        rst = 1'b1; req = 4'd0; out_ready = 1'b0;
        for (int n = 0; n < 4; n++) din[n] = 32'd0;
        m_ptr = 3; m_out = 0; m_src = 0; m_valid = 0; m_sel = 0;
        for (int n = 0; n < 4; n++) m_cnt[n] = 0;
        #1;
        cycle();
        rst = 1'b0;
        cycle();
        check("reset_valid", {63'd0, s_valid}, 64'd0);
        check("reset_out", {32'd0, s_out}, 64'd0);
        check("reset_gnt", {60'd0, s_gnt}, 64'd0);

        // rotation with all requesting
        pat_gnt[0] = 4'b0001; pat_gnt[1] = 4'b0010; pat_gnt[2] = 4'b0100;
        pat_gnt[3] = 4'b1000; pat_gnt[4] = 4'b0001;
        pat_out[0] = 32'd0; pat_out[1] = 32'd1; pat_out[2] = 32'd0; pat_out[3] = 32'd1;
        do_reset();
        req = 4'b1111; out_ready = 1'b1;
        din[0] = 0; din[1] = 1; din[2] = 0; din[3] = 1;
        for (int i = 0; i < 5; i++) begin
            cycle();
            check("rot_gnt", {60'd0, s_gnt}, {60'd0, pat_gnt[i]});
            if (i > 0) begin
                check("rot_out", {32'd0, s_out}, {32'd0, pat_out[i-1]});
                check("rot_src", {62'd0, s_src}, 64'(i - 1));
            end
        end

        // single requester
        req = 4'b0100; din[2] = 32'hA5A5A5A5;
        for (int i = 0; i < 4; i++) begin
            cycle();
            check("single_gnt", {60'd0, s_gnt}, 64'h4);
            check("single_sel", {62'd0, s_sel}, 64'd2);
            if (i > 0) begin
                check("single_out", {32'd0, s_out}, 64'hA5A5A5A5);
                check("single_src", {62'd0, s_src}, 64'd2);
            end
        end

        // backpressure
        do_reset();
        req = 4'b0011; out_ready = 1'b0; din[0] = 32'h1111_0000; din[1] = 32'h2222_0000;
        cycle();
        check("bp_first_gnt", {60'd0, s_gnt}, 64'h1);
        for (int i = 0; i < 5; i++) begin
            cycle();
            check("bp_hold_gnt", {60'd0, s_gnt}, 64'h0);
            check("bp_hold_out", {32'd0, s_out}, 64'h11110000);
            check("bp_hold_valid", {63'd0, s_valid}, 64'd1);
        end
        out_ready = 1'b1;
        cycle();
        check("bp_release_gnt", {60'd0, s_gnt}, 64'h2);
        cycle();
        check("bp_release_out", {32'd0, s_out}, 64'h22220000);

        // pointer wrap
        do_reset();
        req = 4'b1000;
        cycle();
        check("wrap_g3", {60'd0, s_gnt}, 64'h8);
        req = 4'b1001;
        cycle();
        check("wrap_g0", {60'd0, s_gnt}, 64'h1);
        cycle();
        check("wrap_g3b", {60'd0, s_gnt}, 64'h8);

        // reset mid-operation
        req = 4'b1111; out_ready = 1'b0;
        cycle();
        rst = 1'b1;
        cycle();
        check("midrst_gnt", {60'd0, s_gnt}, 64'h0);
        rst = 1'b0;
        cycle();
        check("midrst_valid", {63'd0, s_valid}, 64'd0);
        check("midrst_next_gnt", {60'd0, s_gnt}, 64'h1);

`ifdef ARB_GRANT_CNT_EN
        do_reset();
        req = 4'b1111; out_ready = 1'b1;
        for (int i = 0; i < 10; i++) cycle();
        check("cnt0", {48'd0, grant_cnt[15:0]},  64'd3);
        check("cnt1", {48'd0, grant_cnt[31:16]}, 64'd3);
        check("cnt2", {48'd0, grant_cnt[47:32]}, 64'd2);
        check("cnt3", {48'd0, grant_cnt[63:48]}, 64'd2);
`endif

        // randomized traffic obeying the hold-until-granted rule
        do_reset();
        req = 4'd0;
        for (int i = 0; i < 4000; i++) begin
            pend = req & ~s_gnt;
            for (int n = 0; n < 4; n++) begin
                if (!pend[n]) begin
                    req[n] = ($urandom_range(0, 99) < 45);
                    din[n] = $urandom;
                end
            end
            out_ready = ($urandom_range(0, 99) < 60);
            rst = ($urandom_range(0, 199) == 0);
            cycle();
            if (rst) s_gnt = 4'd0;
        end
        rst = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
